phy_rx_sync_ctrl: RTL
=====================

PHY_RX_SYNC_CTRL -- requirements
Module: phy_rx_sync_ctrl

Interface
REQ-001 Parameter COMMA, default 8'hBC: alignment symbol.
REQ-002 Parameter SYNC_CNT, default 4: consecutive valid COMMA bytes needed to reach ACTIVE.
REQ-003 Parameter LOSS_CNT, default 4: consecutive idle cycles (in_valid=0) in ACTIVE that drop sync.
REQ-004 clk_4f  input  1  byte-rate clock; all logic on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 data_in  input  8  parallel byte from the serial-to-parallel stage.
REQ-007 in_valid  input  1  data_in holds a valid byte this cycle.
REQ-008 active  output  1  receiver synchronised (state ACTIVE).
REQ-009 data_out  output  8  byte forwarded to the 1x4 demux.
REQ-010 valid_out  output  1  data_out valid this cycle.
REQ-011 lane_sel  output  2  destination demux lane for data_out.
REQ-012 comma_cnt  output  3  current consecutive-COMMA count (debug).

Function
REQ-013 FSM states SHALL be SEARCH, COUNT, ACTIVE; all outputs SHALL be registered.
REQ-014 A cycle with in_valid=0 SHALL never be treated as a COMMA or as data.
REQ-015 SEARCH: valid byte == COMMA -> COUNT, comma_cnt=1; any other valid byte -> stay, comma_cnt=0.
REQ-016 COUNT: valid COMMA -> comma_cnt+1; when the increment reaches SYNC_CNT -> ACTIVE, active=1 after that same edge.
REQ-017 COUNT: valid non-COMMA -> SEARCH, comma_cnt=0; in_valid=0 -> hold state and count.
REQ-018 comma_cnt SHALL saturate at SYNC_CNT and clear to 0 on leaving ACTIVE.
REQ-019 ACTIVE: valid non-COMMA byte sampled at edge N -> data_out=byte, valid_out=1, lane_sel=lane pointer, all after edge N (one-cycle latency).
REQ-020 Lane pointer SHALL be 0 on entering ACTIVE and SHALL increment modulo 4 after each forwarded byte (3 wraps to 0).
REQ-021 ACTIVE: valid COMMA SHALL NOT be forwarded (valid_out=0) and SHALL reset the lane pointer to 0.
REQ-022 valid_out SHALL be 0 in every cycle where no byte is forwarded; data_out SHALL hold its last value.
REQ-023 ACTIVE: idle counter SHALL increment on each in_valid=0 cycle and clear on in_valid=1.
REQ-024 The idle counter reaching LOSS_CNT -> SEARCH, active=0, valid_out=0, lane pointer=0, idle counter=0.
REQ-025 active SHALL be 0 in SEARCH and COUNT.

Reset
REQ-026 reset=0 SHALL, asynchronously, set state=SEARCH, active=0, valid_out=0, data_out=8'h00, lane_sel=0, comma_cnt=0, idle counter=0.
REQ-027 reset=0 mid-stream SHALL drop sync immediately; after release, full SYNC_CNT COMMA acquisition SHALL be required again.

Verification
REQ-028 Reset, then valid BC,BC,BC,BC,FF,EE,01,02 -> active=1 after 4th BC; FF lane0, EE lane1, 01 lane2, 02 lane3, each one cycle after its input.
REQ-029 Valid BC,BC,BC,00 -> comma_cnt 1,2,3,0, active stays 0; then 4x BC -> active=1.
REQ-030 ACTIVE, bytes 11,22,BC,33 -> 11 lane0, 22 lane1, BC not forwarded, 33 lane0.
REQ-031 ACTIVE, in_valid=0 for 3 cycles then byte 44 -> active stays 1, 44 forwarded; in_valid=0 for 4 cycles -> active=0 after 4th, state SEARCH.
REQ-032 ACTIVE, 5 data bytes -> lane_sel 0,1,2,3,0; BC,BC with in_valid=0 interleaved in COUNT -> count held, not advanced.
REQ-033 reset=0 between clock edges during ACTIVE -> active, valid_out, lane_sel, comma_cnt go to 0 without a clock edge.

Source files
------------

// File: rtl/phy_rx_sync_ctrl.sv
//------------------------------------------------------------------------------
// phy_rx_sync_ctrl
//
// Purpose:
//   This is the byte-alignment controller of the PHY receiver. It watches the
//   bytes coming out of the serial-to-parallel stage and waits for a run of
//   SYNC_CNT consecutive valid COMMA bytes before it declares the link
//   synchronised (ACTIVE).
//
//   While ACTIVE, every valid non-COMMA byte is forwarded to the 1x4 demux
//   together with the lane it belongs to. The lane pointer advances modulo 4
//   after each forwarded byte. A COMMA seen in ACTIVE is not forwarded and
//   re-aligns the lane pointer to lane 0.
//
//   Sync is lost after LOSS_CNT consecutive idle cycles (in_valid=0) in ACTIVE.
//
// Parameters:
//   COMMA     alignment symbol
//   SYNC_CNT  consecutive valid COMMAs needed to reach ACTIVE (1..7)
//   LOSS_CNT  consecutive idle cycles in ACTIVE that drop sync (>= 1)
//
// Ports:
//   clk_4f     in   1  byte-rate clock, rising edge
//   reset      in   1  asynchronous, active-low reset
//   data_in    in   8  byte from the serial-to-parallel stage
//   in_valid   in   1  data_in holds a valid byte this cycle
//   active     out  1  receiver synchronised
//   data_out   out  8  byte forwarded to the demux (holds when not forwarding)
//   valid_out  out  1  data_out carries a freshly forwarded byte
//   lane_sel   out  2  demux lane for data_out
//   comma_cnt  out  3  consecutive-COMMA count (debug)
//------------------------------------------------------------------------------
module phy_rx_sync_ctrl #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int          SYNC_CNT = 4,
    parameter int          LOSS_CNT = 4
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       in_valid,
    output logic       active,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] lane_sel,
    output logic [2:0] comma_cnt
);

    localparam int                IDLE_W    = $clog2(LOSS_CNT + 1);
    localparam logic [2:0]        SYNC_FULL = 3'(SYNC_CNT);
    localparam logic [IDLE_W-1:0] LOSS_LAST = IDLE_W'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        lane_ptr;
    logic [IDLE_W-1:0] idle_cnt;
    logic              is_comma;

    // An idle cycle must never look like a COMMA, whatever sits on data_in.
    assign is_comma = in_valid && (data_in == COMMA);

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            active    <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= 8'h00;
            lane_sel  <= 2'd0;
            comma_cnt <= 3'd0;
            lane_ptr  <= 2'd0;
            idle_cnt  <= '0;
        end else begin
            // valid_out is a one-cycle strobe; it is raised again only by
            // the forwarding branch below.
            valid_out <= 1'b0;

            case (state)
                SEARCH: begin
                    if (is_comma) begin
                        comma_cnt <= 3'd1;
                        // A one-COMMA acquisition goes straight to ACTIVE.
                        if (SYNC_FULL <= 3'd1) begin
                            state     <= ACTIVE;
                            active    <= 1'b1;
                            comma_cnt <= SYNC_FULL;
                            lane_ptr  <= 2'd0;
                            idle_cnt  <= '0;
                        end else begin
                            state <= COUNT;
                        end
                    end else if (in_valid) begin
                        comma_cnt <= 3'd0;
                    end
                end

                COUNT: begin
                    // Idle cycles leave both the state and the count untouched.
                    if (is_comma) begin
                        if (comma_cnt + 3'd1 == SYNC_FULL) begin
                            state     <= ACTIVE;
                            active    <= 1'b1;
                            comma_cnt <= SYNC_FULL;
                            lane_ptr  <= 2'd0;
                            idle_cnt  <= '0;
                        end else begin
                            comma_cnt <= comma_cnt + 3'd1;
                        end
                    end else if (in_valid) begin
                        state     <= SEARCH;
                        comma_cnt <= 3'd0;
                    end
                end

                ACTIVE: begin
                    if (!in_valid) begin
                        if (idle_cnt == LOSS_LAST) begin
                            state     <= SEARCH;
                            active    <= 1'b0;
                            comma_cnt <= 3'd0;
                            lane_ptr  <= 2'd0;
                            idle_cnt  <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                        if (is_comma) begin
                            // COMMA in ACTIVE re-aligns the lanes; comma_cnt
                            // is already saturated at SYNC_CNT.
                            lane_ptr <= 2'd0;
                        end else begin
                            data_out  <= data_in;
                            valid_out <= 1'b1;
                            lane_sel  <= lane_ptr;
                            lane_ptr  <= lane_ptr + 2'd1;
                        end
                    end
                end

                default: begin
                    state     <= SEARCH;
                    active    <= 1'b0;
                    comma_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule
